// File: rtl/mini_mips_pkg.sv
// Shared miniMIPS definitions: instruction word format and instruction-memory geometry.
package mini_mips_pkg;

    localparam int INSTR_WIDTH     = 16;
    localparam int IMEM_ADDR_WIDTH = 6;
    localparam int IMEM_DEPTH      = 64;

    typedef logic [INSTR_WIDTH-1:0] instr_t;

endpackage

// File: rtl/instruction_memory_block.sv
// Read-only miniMIPS instruction store: flat word array with a single registered read port.
// Contents are loaded by simulation backdoor into instr_memory; there is no write path.
module instruction_memory_block
    import mini_mips_pkg::*;
#(
    parameter int DATA_WIDTH = INSTR_WIDTH,
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DEPTH      = IMEM_DEPTH,
    parameter     INIT_FILE  = ""
) (
    output logic [DATA_WIDTH-1:0] instruction,
    input  logic [ADDR_WIDTH-1:0] read_adress,
    input  logic                  clk,
    input  logic                  rst_n
);

    // INIT_FILE is carried for interface compatibility; loading is done by the bench backdoor.
    localparam bit init_file_unused = (INIT_FILE == "");

    logic [DATA_WIDTH-1:0] instr_memory [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] read_word;

    generate
        if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_partial
            always_comb begin
                read_word = '0;
                if (int'(read_adress) < DEPTH)
                    read_word = instr_memory[read_adress];
            end
        end else begin : g_full
            always_comb begin
                read_word = instr_memory[read_adress];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instruction <= '0;
        else
            instruction <= read_word;
    end

endmodule

// File: tb/tb_instruction_memory_block.sv
// Randomised self-checking bench for instruction_memory_block against a word-array model.
module tb_instruction_memory_block;
    import mini_mips_pkg::*;

    logic [15:0] instruction;
    logic [5:0]  read_adress;
    logic        clk;
    logic        rst_n;

    instr_t model_mem [0:63];
    instr_t expected;
    int     n_checks;
    int     n_fail;

    instruction_memory_block dut (
        .instruction (instruction),
        .read_adress (read_adress),
        .clk         (clk),
        .rst_n       (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %h (t=%0t)", tag, got, $time);
        end
    endtask

    task automatic poke(input int idx, input instr_t val);
        model_mem[idx] = val;
        dut.instr_memory[idx] = val;
    endtask

    // Apply an address on the falling edge, then observe just after the next rising edge.
    task automatic read_cycle(input logic [5:0] addr, input string tag);
        @(negedge clk);
        read_adress = addr;
        @(posedge clk);
        #1;
        expected = rst_n ? model_mem[addr] : 16'h0000;
        check_value(tag, instruction, expected);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        read_adress = 6'd0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;

        for (int i = 0; i < 64; i++)
            poke(i, instr_t'($urandom));

        // Reset held: edges must be ignored.
        for (int i = 0; i < 3; i++) begin
            read_adress = 6'(i + 1);
            @(posedge clk);
            #1 check_value("reset_held", instruction, 16'h0000);
        end

        @(negedge clk);
        read_adress = 6'd0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1 check_value("first_after_release", instruction, model_mem[0]);

        poke(0, 16'b0000_0001_0010_0011);
        read_cycle(6'd0, "addr0");

        // Latency and hold around address 7.
        poke(7, 16'hA5C3);
        @(negedge clk);
        read_adress = 6'd7;
        #2 check_value("addr7_before_edge", instruction, 16'b0000_0001_0010_0011);
        @(posedge clk);
        #1 check_value("addr7_after_edge", instruction, 16'hA5C3);
        read_adress = 6'd0;
        @(negedge clk);
        #1 check_value("addr7_falling_hold", instruction, 16'hA5C3);

        poke(63, 16'hFFFE);
        read_cycle(6'd63, "addr63");

        // Asynchronous reset mid-cycle; memory must survive.
        read_cycle(6'd7, "addr7_pre_reset");
        #2 rst_n = 1'b0;
        #1 check_value("async_reset_clear", instruction, 16'h0000);
        @(posedge clk);
        #1 check_value("async_reset_hold", instruction, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        read_cycle(6'd7, "addr7_retained");

        for (int i = 0; i < 64; i++)
            poke(i, instr_t'(i * 16'h0101));
        for (int i = 0; i < 64; i++)
            read_cycle(6'(i), $sformatf("sweep_%0d", i));

        // Random reads with mid-cycle address wiggles and occasional reset pulses.
        for (int i = 0; i < 64; i++)
            poke(i, instr_t'($urandom));
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_value("rand_reset", instruction, 16'h0000);
                @(posedge clk);
                #1 check_value("rand_reset_hold", instruction, 16'h0000);
                @(negedge clk);
                rst_n = 1'b1;
            end
            read_cycle(6'($urandom), "rand_read");
            #2 read_adress = 6'($urandom);
            #1 check_value("rand_hold", instruction, expected);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
